// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester and RAM-side bus bundle for ram_arbiter
interface ram_arbiter_if #(
  parameter int addr_size = 16,
  parameter int data_size = 16
);
  logic [1:0]           req_i;
  logic [1:0]           we_i;
  logic [1:0]           lock_i;
  logic [addr_size-1:0] addr0_i;
  logic [addr_size-1:0] addr1_i;
  logic [data_size-1:0] wdata0_i;
  logic [data_size-1:0] wdata1_i;
  logic [1:0]           gnt_o;
  logic [1:0]           rvalid_o;
  logic [data_size-1:0] rdata_o;
  logic                 ram_wenable;
  logic [addr_size-1:0] ram_waddr;
  logic [data_size-1:0] ram_wdata;
  logic [addr_size-1:0] ram_raddr;
  logic [data_size-1:0] ram_rdata;

  modport slave (
    input  req_i, we_i, lock_i, addr0_i, addr1_i, wdata0_i, wdata1_i, ram_rdata,
    output gnt_o, rvalid_o, rdata_o, ram_wenable, ram_waddr, ram_wdata, ram_raddr
  );

  modport master (
    output req_i, we_i, lock_i, addr0_i, addr1_i, wdata0_i, wdata1_i, ram_rdata,
    input  gnt_o, rvalid_o, rdata_o, ram_wenable, ram_waddr, ram_wdata, ram_raddr
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing one RAM between two requesters
// Grants one access per cycle, supports a one-owner lock for read-modify-write.
module ram_arbiter #(
  parameter int addr_size = 16,
  parameter int data_size = 16
) (
  input  logic         clk,
  input  logic         rstn,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_FREE  = 2'd0,
    S_LOCK0 = 2'd1,
    S_LOCK1 = 2'd2
  } lock_state_t;

  lock_state_t          lock_state;
  logic                 prio;
  logic [1:0]           gnt;
  logic                 granted;
  logic                 gidx;
  logic                 gwe;
  logic                 glock;
  logic [addr_size-1:0] gaddr;
  logic [data_size-1:0] gwdata;
  logic [1:0]           rvalid;
  logic [data_size-1:0] rdata;

  // Grant is gated by rstn so nothing reaches the RAM while in reset.
  always_comb begin
    gnt = 2'b00;
    if (rstn) begin
      case (lock_state)
        S_LOCK0: gnt = {1'b0, bus.req_i[0]};
        S_LOCK1: gnt = {bus.req_i[1], 1'b0};
        default: begin
          case (bus.req_i)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
          endcase
        end
      endcase
    end
  end

  assign granted = |gnt;
  assign gidx    = gnt[1];
  assign gwe     = bus.we_i[gidx];
  assign glock   = bus.lock_i[gidx];
  assign gaddr   = gidx ? bus.addr1_i  : bus.addr0_i;
  assign gwdata  = gidx ? bus.wdata1_i : bus.wdata0_i;

  assign bus.gnt_o       = gnt;
  assign bus.ram_wenable = granted & gwe;
  assign bus.ram_waddr   = gaddr;
  assign bus.ram_raddr   = gaddr;
  assign bus.ram_wdata   = gwdata;
  assign bus.rvalid_o    = rvalid;
  assign bus.rdata_o     = rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_state <= S_FREE;
      prio       <= 1'b0;
      rvalid     <= 2'b00;
      rdata      <= '0;
    end else begin
      rvalid <= 2'b00;
      if (granted && !gwe) begin
        rvalid <= gnt;
        rdata  <= bus.ram_rdata;
      end

      if (granted) begin
        if (lock_state == S_FREE) begin
          prio <= ~gidx;
        end
        if (glock) begin
          lock_state <= gidx ? S_LOCK1 : S_LOCK0;
        end else begin
          lock_state <= S_FREE;
        end
      end else if (lock_state != S_FREE) begin
        // A locked cycle without a grant means the owner dropped its request.
        lock_state <= S_FREE;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed bench for ram_arbiter with a behavioural reference model
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.addr_size(16), .data_size(16)) bus ();

  ram_arbiter #(.addr_size(16), .data_size(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [15:0] ram     [0:65535];
  logic [15:0] ref_mem [0:65535];

  assign bus.ram_rdata = ram[bus.ram_raddr];

  always @(posedge clk) begin
    if (bus.ram_wenable) ram[bus.ram_waddr] <= bus.ram_wdata;
  end

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  int          m_prio = 0;
  int          m_owner = 0;
  bit          m_locked = 1'b0;
  logic [1:0]  m_rvalid = 2'b00;
  logic [15:0] m_rdata = 16'h0000;

  always @(negedge clk) begin : model_cmp
    logic [1:0]  eg;
    int          g;
    bit          ew;
    logic [15:0] ea;
    logic [15:0] ed;
    if (!rstn) begin
      chk("rst_gnt", bus.gnt_o, 2'b00);
      chk("rst_rvalid", bus.rvalid_o, 2'b00);
      chk("rst_rdata", bus.rdata_o, 16'h0000);
      chk("rst_wen", bus.ram_wenable, 1'b0);
      m_prio = 0; m_owner = 0; m_locked = 1'b0; m_rvalid = 2'b00; m_rdata = 16'h0000;
    end else begin
      chk("m_rvalid", bus.rvalid_o, m_rvalid);
      chk("m_rdata", bus.rdata_o, m_rdata);
      if (m_locked) eg = bus.req_i[m_owner] ? 2'(1 << m_owner) : 2'b00;
      else if (bus.req_i == 2'b11) eg = 2'(1 << m_prio);
      else eg = bus.req_i;
      chk("m_gnt", bus.gnt_o, eg);
      g  = (eg == 2'b10) ? 1 : 0;
      ew = (eg != 2'b00) && bus.we_i[g];
      ea = (g == 1) ? bus.addr1_i : bus.addr0_i;
      ed = (g == 1) ? bus.wdata1_i : bus.wdata0_i;
      chk("m_wen", bus.ram_wenable, ew);
      chk("m_raddr", bus.ram_raddr, ea);
      chk("m_waddr", bus.ram_waddr, ea);
      chk("m_wdata", bus.ram_wdata, ed);
      m_rvalid = 2'b00;
      if (eg != 2'b00 && !bus.we_i[g]) begin
        m_rvalid = eg;
        m_rdata  = ref_mem[ea];
      end
      if (ew) ref_mem[ea] = ed;
      if (eg != 2'b00) begin
        if (!m_locked) m_prio = 1 - g;
        m_locked = bus.lock_i[g];
        if (bus.lock_i[g]) m_owner = g;
      end else if (m_locked) begin
        m_locked = 1'b0;
      end
    end
  end

  task automatic cyc(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                     input logic [15:0] a0, input logic [15:0] a1,
                     input logic [15:0] d0, input logic [15:0] d1);
    @(posedge clk);
    #1;
    bus.req_i = r; bus.we_i = w; bus.lock_i = l;
    bus.addr0_i = a0; bus.addr1_i = a1; bus.wdata0_i = d0; bus.wdata1_i = d1;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    bus.req_i = 2'b00; bus.we_i = 2'b00; bus.lock_i = 2'b00;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    bus.req_i = 2'b00; bus.we_i = 2'b00; bus.lock_i = 2'b00;
    bus.addr0_i = 16'h0; bus.addr1_i = 16'h0; bus.wdata0_i = 16'h0; bus.wdata1_i = 16'h0;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt", bus.gnt_o, 2'b00);
    chk("reset_rvalid", bus.rvalid_o, 2'b00);
    chk("reset_rdata", bus.rdata_o, 16'h0000);
    chk("reset_wen", bus.ram_wenable, 1'b0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // 1: single read
    cyc(2'b01, 2'b00, 2'b00, 16'h0010, 16'h0, 16'h0, 16'h0);
    chk("t1_gnt", bus.gnt_o, 2'b01);
    idle();
    chk("t1_rvalid", bus.rvalid_o, 2'b01);
    chk("t1_rdata", bus.rdata_o, 16'h0000);

    // 2: write then read-back by the other port
    cyc(2'b01, 2'b01, 2'b00, 16'h0010, 16'h0, 16'hBEEF, 16'h0);
    chk("t2_gnt_w", bus.gnt_o, 2'b01);
    chk("t2_wen", bus.ram_wenable, 1'b1);
    chk("t2_waddr", bus.ram_waddr, 16'h0010);
    chk("t2_wdata", bus.ram_wdata, 16'hBEEF);
    cyc(2'b10, 2'b00, 2'b00, 16'h0, 16'h0010, 16'h0, 16'h0);
    chk("t2_gnt_r", bus.gnt_o, 2'b10);
    idle();
    chk("t2_rvalid", bus.rvalid_o, 2'b10);
    chk("t2_rdata", bus.rdata_o, 16'hBEEF);

    // 3: both requesting continuously from reset alternate
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0011, 16'h0, 16'h0);
      chk("t3_gnt", bus.gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) begin
        chk("t3_rvalid", bus.rvalid_o, (i % 2 == 0) ? 2'b10 : 2'b01);
        chk("t3_rdata", bus.rdata_o, (i % 2 == 0) ? 16'h0000 : 16'hBEEF);
      end
    end
    idle();

    // 4: requester 1 locked read-modify-write while requester 0 waits
    cyc(2'b01, 2'b00, 2'b00, 16'h0030, 16'h0, 16'h0, 16'h0);
    chk("t4_pre_gnt", bus.gnt_o, 2'b01);
    cyc(2'b11, 2'b00, 2'b10, 16'h0040, 16'h0020, 16'h0, 16'h0);
    chk("t4_gnt_a", bus.gnt_o, 2'b10);
    cyc(2'b11, 2'b10, 2'b00, 16'h0040, 16'h0020, 16'h0, 16'h1234);
    chk("t4_gnt_b", bus.gnt_o, 2'b10);
    chk("t4_wen", bus.ram_wenable, 1'b1);
    chk("t4_rvalid", bus.rvalid_o, 2'b10);
    cyc(2'b01, 2'b00, 2'b00, 16'h0040, 16'h0, 16'h0, 16'h0);
    chk("t4_gnt_c", bus.gnt_o, 2'b01);
    cyc(2'b10, 2'b00, 2'b00, 16'h0, 16'h0020, 16'h0, 16'h0);
    idle();
    chk("t4_readback", bus.rdata_o, 16'h1234);

    // 6: locked owner drops its request
    cyc(2'b10, 2'b00, 2'b10, 16'h0, 16'h0050, 16'h0, 16'h0);
    chk("t6_gnt_lock", bus.gnt_o, 2'b10);
    cyc(2'b01, 2'b00, 2'b00, 16'h0060, 16'h0, 16'h0, 16'h0);
    chk("t6_gnt_none", bus.gnt_o, 2'b00);
    cyc(2'b01, 2'b00, 2'b00, 16'h0060, 16'h0, 16'h0, 16'h0);
    chk("t6_gnt_next", bus.gnt_o, 2'b01);
    idle();

    // 5: reset right after a read grant, with a write pending during reset
    cyc(2'b01, 2'b00, 2'b00, 16'h0010, 16'h0, 16'h0, 16'h0);
    chk("t5_gnt", bus.gnt_o, 2'b01);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    bus.we_i = 2'b01; bus.wdata0_i = 16'hDEAD;
    @(negedge clk);
    chk("t5_rvalid", bus.rvalid_o, 2'b00);
    chk("t5_gnt_rst", bus.gnt_o, 2'b00);
    chk("t5_wen", bus.ram_wenable, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    bus.req_i = 2'b11; bus.we_i = 2'b00; bus.addr0_i = 16'h0010; bus.addr1_i = 16'h0011;
    @(negedge clk);
    chk("t5_prio", bus.gnt_o, 2'b01);
    idle();
    chk("t5_rdata", bus.rdata_o, 16'hBEEF);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
